ula_seq_ctrl: RTL
=================

Name: ula_seq_ctrl

Overview:
- Byte-serial sequencer that executes one NBYTES-wide 74181-style operation on a single shared ula_8bits instance, one byte-slice per cycle.
- Carry is chained through a register between slices.
- Sits between a requester (valid/ready operand/opcode stream) and the 8-bit ULA datapath, so wide operations run without widening the ALU.

Parameters:
- NBYTES, 4, number of 8-bit slices per operation (≥2); operand width W = 8*NBYTES.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  sequencer can accept a request.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_s  in  4  74181 function select.
- in_m  in  1  mode: 0 = arithmetic, 1 = logic.
- in_c_in  in  1  carry into byte 0, passed raw to ula_8bits c_in (same polarity).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_f  out  W  result.
- out_c_out  out  1  c_out of the most-significant slice.
- out_a_eq_b  out  1  AND of all slice a_eq_b outputs.
- busy  out  1  high in RUN.

Behaviour:
- States:
  - IDLE: in_ready=1. On in_valid: latch a, b, s, m, c_in into operand registers, clear byte index k=0, set carry register to in_c_in, set eq accumulator to 1, go to RUN.
  - RUN: drive ula_8bits with a[8k+7:8k], b[8k+7:8k], the latched s and m, and the carry register.
    - Each cycle: write f into out_f byte k, load the carry register with c_out, AND slice a_eq_b into the accumulator, k++.
    - When k==NBYTES-1, go to DONE.
  - DONE: out_valid=1. On out_ready: go to IDLE.
- Latency: accept edge plus NBYTES RUN cycles; out_valid rises on the edge ending the last slice. Total NBYTES+1 edges from accept to out_valid.
- Throughput: one operation per NBYTES+2 cycles minimum. No accept in DONE; no bypass of IDLE.
- out_f, out_c_out and out_a_eq_b are stable and held in DONE until the handshake completes.
- out_c_out is the carry register after the final slice. out_a_eq_b is the accumulator.
- Inputs changing during RUN/DONE are ignored. Only latched values are used.
- out_valid held with out_ready low: state stays DONE indefinitely, outputs unchanged.
- in_valid asserted outside IDLE: ignored; the requester must hold it until in_ready.
- Reset (asynchronous, any state, including mid-RUN): state=IDLE, k=0, carry register=0, accumulator=1.
  - Outputs on reset: in_ready=1, out_valid=0, busy=0, out_f=0, out_c_out=0, out_a_eq_b=0.
  - The aborted operation produces no output.
- The byte index is $clog2(NBYTES) bits wide and never wraps past NBYTES-1.

Optional Feature:
- Macro: ULA_SEQ_ZERO_FLAG_EN.
- Defined: adds output port out_zero (1 bit).
  - Accumulator set to 1 on accept; ANDed each RUN cycle with (slice f == 0).
  - Valid with out_valid; reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package ula_seq_pkg:
  - state enum (IDLE, RUN, DONE).
  - localparam SLICE_W = 8.
  - function computing the index width from NBYTES.
- Sub-module: the existing ula_8bits, instantiated once as the datapath. The FSM and slice registers stay in ula_seq_ctrl.

Test Plan:
- Logic XOR: m=1, s=4'b0110, a=0x12345678, b=0xFFFF0000 → after 5 edges out_valid=1, out_f=0xEDCB5678, out_a_eq_b=0.
- Carry chain: m=0, s=4'b1001 (A plus B), in_c_in at ula_8bits no-carry level, a=0x000000FF, b=0x00000001 → out_f=0x00000100.
  - Also: out_c_out at no-carry level; the slice-1 carry register is observed in carry state after slice 0.
- Equality: subtract-mode select with a=b=0xA5A5A5A5 → out_a_eq_b=1. Repeat with b=0xA5A5A5A4 → out_a_eq_b=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → outputs and DONE held, in_ready=0, second in_valid not accepted; release → IDLE next edge, then accept.
- Reset mid-RUN: assert rst after 2 RUN cycles → immediately out_valid=0, busy=0, in_ready=1, out_f=0. A new request afterwards completes correctly.
- With ULA_SEQ_ZERO_FLAG_EN: XOR a=b=0xDEADBEEF → out_zero=1; a=0x1, b=0 → out_zero=0.

Source files
------------

// File: rtl/ula_seq_pkg.sv
// Shared types and helpers for the byte-serial 74181 sequencer.
package ula_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 8;

  function automatic int idx_width(input int nbytes);
    return (nbytes < 2) ? 1 : $clog2(nbytes);
  endfunction

endpackage

// File: rtl/ula_8bits.sv
// 8-bit 74181-style ALU slice, active-high data.
// Carry pins are active low as on the original part: c_in=1 means no carry in.
module ula_8bits (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       c_in,
  output logic [7:0] f,
  output logic       c_out,
  output logic       a_eq_b
);

  logic [7:0] p_term;
  logic [7:0] g_term;
  logic [8:0] sum;

  // The arithmetic result is always p_term plus g_term plus carry.
  assign p_term = a | (b & {8{s[0]}}) | (~b & {8{s[1]}});
  assign g_term = (a & ~b & {8{s[2]}}) | (a & b & {8{s[3]}});
  assign sum    = {1'b0, p_term} + {1'b0, g_term} + {8'd0, ~c_in};

  assign f      = m ? ~(p_term ^ g_term) : sum[7:0];
  assign c_out  = m ? 1'b1 : ~sum[8];
  assign a_eq_b = &f;

endmodule

// File: rtl/ula_seq_ctrl.sv
// Runs one NBYTES-wide 74181 operation through a single ula_8bits, one byte per cycle.
// Optional out_zero flag is enabled by defining ULA_SEQ_ZERO_FLAG_EN.
module ula_seq_ctrl
  import ula_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   in_a,
  input  logic [8*NBYTES-1:0]   in_b,
  input  logic [3:0]            in_s,
  input  logic                  in_m,
  input  logic                  in_c_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   out_f,
  output logic                  out_c_out,
  output logic                  out_a_eq_b,
`ifdef ULA_SEQ_ZERO_FLAG_EN
  output logic                  out_zero,
`endif
  output logic                  busy
);

  localparam int W     = SLICE_W * NBYTES;
  localparam int IDX_W = idx_width(NBYTES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   k_q, k_d;
  logic               carry_q, carry_d;
  logic               eq_q, eq_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d;
  logic [3:0]         s_q, s_d;
  logic               m_q, m_d;
  logic [W-1:0]       out_f_q, out_f_d;

  logic [SLICE_W-1:0] sl_a, sl_b, sl_f;
  logic               sl_c_out, sl_eq;

  assign sl_a = a_q[k_q*SLICE_W +: SLICE_W];
  assign sl_b = b_q[k_q*SLICE_W +: SLICE_W];

  ula_8bits u_ula (
    .a      (sl_a),
    .b      (sl_b),
    .s      (s_q),
    .m      (m_q),
    .c_in   (carry_q),
    .f      (sl_f),
    .c_out  (sl_c_out),
    .a_eq_b (sl_eq)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    eq_d    = eq_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    m_d     = m_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          s_d     = in_s;
          m_d     = in_m;
          k_d     = '0;
          carry_d = in_c_in;
          eq_d    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d = sl_c_out;
        eq_d    = eq_q & sl_eq;
        if (k_q == LAST) begin
          state_d = DONE;
        end else begin
          k_d = k_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_byte
    assign out_f_d[gi*SLICE_W +: SLICE_W] =
      (state_q == RUN && k_q == IDX_W'(gi)) ? sl_f : out_f_q[gi*SLICE_W +: SLICE_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      eq_q    <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      out_f_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      eq_q    <= eq_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      m_q     <= m_d;
      out_f_q <= out_f_d;
    end
  end

`ifdef ULA_SEQ_ZERO_FLAG_EN
  logic zero_q, zero_d;

  always_comb begin
    zero_d = zero_q;
    if (state_q == IDLE && in_valid) begin
      zero_d = 1'b1;
    end else if (state_q == RUN) begin
      zero_d = zero_q & (sl_f == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q <= 1'b1;
    end else begin
      zero_q <= zero_d;
    end
  end

  assign out_zero = (state_q == DONE) & zero_q;
`endif

  // Flags are only meaningful alongside out_valid; they read 0 otherwise.
  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q == RUN);
  assign out_valid  = (state_q == DONE);
  assign out_f      = out_f_q;
  assign out_c_out  = (state_q == DONE) & carry_q;
  assign out_a_eq_b = (state_q == DONE) & eq_q;

endmodule
